rng_bounded: RTL
================

// Module: rng_bounded
// PURPOSE
//  Consumer stage behind the Mersenne-Twister rng block.
//  - Requests 32-bit words over the rng start/valid handshake.
//  - Reduces each word to a uniform integer in [0,LIMIT) by mask-and-reject sampling.
//  - Buffers accepted values in a small FWFT FIFO with a ready/valid output.
//  - Lets downstream logic (dice, shufflers, test stimulus) draw bounded randoms without stalling on rng latency.
// PARAMETERS
//  LIMIT  100  exclusive upper bound of output range; must be >=2
//  DEPTH  8    FIFO depth in entries; power of two, >=2
//  W      $clog2(LIMIT)  derived output width; localparam, not overridable
// PORTS
//  clk        in   1   system clock, all state on rising edge
//  rst        in   1   asynchronous reset, active-high
//  en         in   1   1 = keep FIFO topped up; 0 = issue no new requests
//  rng_start  out  1   one-cycle request pulse to the rng start input
//  rng_valid  in   1   rng valid; held high until the next start
//  rng_data   in   32  rng rand_out
//  out_valid  out  1   FIFO head holds a value
//  out_ready  in   1   consumer accepts the head this cycle
//  out_data   out  W   FIFO head value, always < LIMIT while out_valid=1
//  level      out  $clog2(DEPTH+1)  current FIFO occupancy
// BEHAVIOUR
//  Reset (async, immediate): rng_start=0, out_valid=0, out_data=0, level=0; FSM=IDLE; FIFO pointers=0.
//  FSM
//   IDLE: if en && level<DEPTH -> REQ; else stay.
//   REQ:  rng_start=1 for exactly this cycle -> WAIT.
//         rng clears its valid on the same edge, so WAIT never sees stale valid.
//   WAIT: hold until rng_valid=1, then evaluate sample s=rng_data[W-1:0] that cycle -> IDLE.
//         en is ignored here; an outstanding request always completes.
//  Sampling rule
//   - Accept iff s<LIMIT: push s into the FIFO on that edge.
//   - Otherwise discard; the FSM returns to IDLE and re-requests.
//   - LIMIT a power of two: never rejects. Worst-case accept rate >1/2.
//  At most one request is in flight. Requests are issued only when level<DEPTH, so a push never meets a full FIFO.
//  FIFO
//   - First-word fall-through. Pop happens when out_valid && out_ready.
//   - Push into an empty FIFO: out_valid=1 and out_data valid on the cycle after the push edge.
//   - Push and pop on the same edge: level unchanged, data order preserved.
//   - Pop while empty: no effect.
//   - Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
//  Throughput: at most one value per rng latency (~6 cycles per word, plus ~N cycles per rng refill) + 2 FSM cycles.
//  Before rng init completes, WAIT simply lasts longer. The block does not track rng init.
//  en 1->0: an in-flight request completes and its accepted value is pushed. FIFO contents stay poppable.
// CONFIGURATION
//  RNG_BOUNDED_STATS_EN defined:
//   - Adds output port rejects [15:0]: count of discarded samples.
//   - Saturates at 16'hFFFF; cleared by rst only.
//  Not defined: port and counter absent; behaviour otherwise identical.
// TESTING
//  1. Stub rng, LIMIT=100. en=1, stub returns 32'h00000005 -> one rng_start pulse, then out_data=5, out_valid=1, level=1.
//  2. Stub returns 32'h0000007F, then 32'h00000063 -> 127 discarded, second pulse issued, only 99 output; rejects=1 if STATS_EN.
//  3. out_ready=0, en=1 -> exactly 8 accepted pushes, level=8, no rng_start afterwards.
//     Pop one -> exactly one further request.
//  4. Real rng, SEED=5489, LIMIT=100 -> first word 32'hD091BB5C, low 7 bits = 92 -> first out_data=92.
//  5. rst asserted mid-WAIT with no clock edge -> rng_start=0, out_valid=0, level=0 immediately.
//     After release, normal refill resumes.
//  6. level=1, push and pop on the same edge -> level stays 1; next head is the new value.

Source files
------------

// File: rtl/rng_bounded.sv
// Bounded random source: pulls 32-bit words from the rng, keeps samples below LIMIT, queues them in an FWFT FIFO.
// Optional reject counter port enabled by defining RNG_BOUNDED_STATS_EN.
`timescale 1ns/1ps
module rng_bounded #(
  parameter int LIMIT = 100,
  parameter int DEPTH = 8,
  localparam int W  = $clog2(LIMIT),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic          rng_start,
  input  logic          rng_valid,
  input  logic [31:0]   rng_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_data,
  output logic [LW-1:0] level
`ifdef RNG_BOUNDED_STATS_EN
  ,
  output logic [15:0]   rejects
`endif
);

  localparam int PW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t        state_reg;
  logic          rng_start_reg;
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [LW-1:0] level_reg;
  logic [W-1:0]  mem [DEPTH];

  logic [W-1:0]  sample;
  logic          accept;
  logic          sample_evt;
  logic          push;
  logic          pop;
  logic          fifo_nonempty;
  logic          unused_hi;

  // Mask-and-reject: only the low W bits matter; the rest of the word is discarded.
  assign sample        = rng_data[W-1:0];
  assign unused_hi     = ^rng_data[31:W];
  assign accept        = ({{(32-W){1'b0}}, sample} < 32'(LIMIT));
  assign sample_evt    = (state_reg == WAIT) && rng_valid;
  assign push          = sample_evt && accept;
  assign fifo_nonempty = (level_reg != '0);
  assign pop           = fifo_nonempty && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      rng_start_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          rng_start_reg <= 1'b0;
          if (en && (level_reg < LW'(DEPTH))) begin
            state_reg     <= REQ;
            rng_start_reg <= 1'b1;
          end
        end
        REQ: begin
          rng_start_reg <= 1'b0;
          state_reg     <= WAIT;
        end
        WAIT: begin
          rng_start_reg <= 1'b0;
          // Outstanding request always completes, regardless of en.
          if (rng_valid) begin
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg     <= IDLE;
          rng_start_reg <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage needs no reset; the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= sample;
    end
  end

  assign rng_start = rng_start_reg;
  assign out_valid = fifo_nonempty;
  assign out_data  = fifo_nonempty ? mem[rd_ptr_reg] : '0;
  assign level     = level_reg;

`ifdef RNG_BOUNDED_STATS_EN
  logic [15:0] rejects_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rejects_reg <= '0;
    end else if (sample_evt && !accept && (rejects_reg != 16'hFFFF)) begin
      rejects_reg <= rejects_reg + 16'd1;
    end
  end

  assign rejects = rejects_reg;
`endif

endmodule
